// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between an icache and a dcache.
// Only one memory transaction is in flight at a time; a read that never returns is completed by a timeout.
module cache_mem_arbiter #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         i_inst_addr,
  input  logic [DATA_W/8-1:0] i_inst_byte_en,
  input  logic [DATA_W-1:0]   i_inst_writedata,
  input  logic                i_inst_read,
  input  logic                i_inst_write,
  output logic [DATA_W-1:0]   o_inst_readdata,
  output logic                o_inst_readdata_valid,
  output logic                o_inst_waitrequest,
  input  logic [31:0]         i_data_addr,
  input  logic [DATA_W/8-1:0] i_data_byte_en,
  input  logic [DATA_W-1:0]   i_data_writedata,
  input  logic                i_data_read,
  input  logic                i_data_write,
  output logic [DATA_W-1:0]   o_data_readdata,
  output logic                o_data_readdata_valid,
  output logic                o_data_waitrequest,
  output logic [31:0]         o_mem_addr,
  output logic [DATA_W/8-1:0] o_mem_byte_en,
  output logic [DATA_W-1:0]   o_mem_writedata,
  output logic                o_mem_read,
  output logic                o_mem_write,
  input  logic [DATA_W-1:0]   i_mem_readdata,
  input  logic                i_mem_readdata_valid,
  input  logic                i_mem_waitrequest,
  output logic                o_timeout
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StIReq, StDReq, StIWait, StDWait} state_e;

  state_e     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;  // 1: dcache was granted last
  logic [7:0] cnt_q, cnt_d;

  logic inst_req, data_req, tmo_hit;
  logic own_data, in_req, in_wait;
  logic g_read, g_write;

  assign inst_req = i_inst_read | i_inst_write;
  assign data_req = i_data_read | i_data_write;
  assign own_data = (state_q == StDReq) || (state_q == StDWait);
  assign in_req   = (state_q == StIReq) || (state_q == StDReq);
  assign in_wait  = (state_q == StIWait) || (state_q == StDWait);
  assign g_read   = own_data ? i_data_read : i_inst_read;
  assign g_write  = own_data ? i_data_write : i_inst_write;
  // Real read data wins over a timeout landing in the same cycle.
  assign tmo_hit  = in_wait && (cnt_q == TimeoutCnt) && !i_mem_readdata_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = '0;
    unique case (state_q)
      StIdle: begin
        if (data_req && (!inst_req || !last_gnt_q)) begin
          state_d    = StDReq;
          last_gnt_d = 1'b1;
        end else if (inst_req) begin
          state_d    = StIReq;
          last_gnt_d = 1'b0;
        end
      end
      StIReq, StDReq: begin
        if (!g_read && !g_write) begin
          state_d = StIdle;
        end else if (!i_mem_waitrequest) begin
          // Read together with write counts as a write.
          if (g_write)                state_d = StIdle;
          else if (state_q == StIReq) state_d = StIWait;
          else                        state_d = StDWait;
        end
      end
      StIWait, StDWait: begin
        if (i_mem_readdata_valid || tmo_hit) state_d = StIdle;
        else                                 cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_mem_addr            = '0;
    o_mem_byte_en         = '0;
    o_mem_writedata       = '0;
    o_mem_read            = 1'b0;
    o_mem_write           = 1'b0;
    o_inst_waitrequest    = 1'b1;
    o_data_waitrequest    = 1'b1;
    o_inst_readdata_valid = 1'b0;
    o_data_readdata_valid = 1'b0;
    o_inst_readdata       = i_mem_readdata;
    o_data_readdata       = i_mem_readdata;
    o_timeout             = 1'b0;
    if (in_req) begin
      o_mem_addr      = own_data ? i_data_addr : i_inst_addr;
      o_mem_byte_en   = own_data ? i_data_byte_en : i_inst_byte_en;
      o_mem_writedata = own_data ? i_data_writedata : i_inst_writedata;
      o_mem_read      = g_read & ~g_write;
      o_mem_write     = g_write;
      if (own_data) o_data_waitrequest = i_mem_waitrequest;
      else          o_inst_waitrequest = i_mem_waitrequest;
    end else if (in_wait && (i_mem_readdata_valid || tmo_hit)) begin
      o_timeout = tmo_hit;
      if (own_data) begin
        o_data_readdata_valid = 1'b1;
        if (tmo_hit) o_data_readdata = '0;
      end else begin
        o_inst_readdata_valid = 1'b1;
        if (tmo_hit) o_inst_readdata = '0;
      end
    end
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter
Interface
REQ-001 Parameter: DATA_W, 128, line data width; byte-enable width is DATA_W/8; address width fixed 32.
REQ-002 Parameter: TIMEOUT, 255, max cycles awaiting read data before forced completion.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 i_inst_addr  in  32  icache request address.
REQ-006 i_inst_byte_en  in  DATA_W/8  icache byte enables.
REQ-007 i_inst_writedata  in  DATA_W  icache write data.
REQ-008 i_inst_read  in  1  icache read request.
REQ-009 i_inst_write  in  1  icache write request.
REQ-010 o_inst_readdata  out  DATA_W  read data to icache.
REQ-011 o_inst_readdata_valid  out  1  read data valid to icache.
REQ-012 o_inst_waitrequest  out  1  stall to icache.
REQ-013 i_data_addr, i_data_byte_en, i_data_writedata, i_data_read, i_data_write  in  as REQ-005..009  dcache request fields.
REQ-014 o_data_readdata, o_data_readdata_valid, o_data_waitrequest  out  as REQ-010..012  dcache response fields.
REQ-015 o_mem_addr, o_mem_byte_en, o_mem_writedata, o_mem_read, o_mem_write  out  as REQ-005..009  shared memory port request.
REQ-016 i_mem_readdata  in  DATA_W  memory read data.
REQ-017 i_mem_readdata_valid  in  1  memory read data valid.
REQ-018 i_mem_waitrequest  in  1  memory stall.
REQ-019 o_timeout  out  1  one-cycle pulse on read timeout.
Function
REQ-020 FSM states: IDLE, I_REQ, D_REQ, I_WAIT, D_WAIT; one memory transaction in flight.
REQ-021 IDLE: a master requests when read|write is high; one requester is granted, next state I_REQ/D_REQ; the memory port is driven from the following cycle (1-cycle arbitration latency).
REQ-022 Both requesting in IDLE: grant the master not granted last (round-robin); the last-grant register resets to inst, so dcache wins the first tie.
REQ-023 x_REQ: granted master's request fields pass combinationally to o_mem_*; its waitrequest equals i_mem_waitrequest.
REQ-024 x_REQ, write with i_mem_waitrequest=0: write accepted, next IDLE.
REQ-025 x_REQ, read with i_mem_waitrequest=0: read accepted, next x_WAIT.
REQ-026 Read and write both high: treated as write, o_mem_read forced 0.
REQ-027 Granted master drops read and write in x_REQ: next IDLE, no memory request issued that cycle.
REQ-028 x_WAIT: o_mem_read/o_mem_write=0; owner waitrequest=1; on i_mem_readdata_valid, owner readdata_valid=1 for that cycle, next IDLE.
REQ-029 o_inst_readdata and o_data_readdata both equal i_mem_readdata; only the owner's readdata_valid asserts.
REQ-030 i_mem_readdata_valid outside x_WAIT is ignored.
REQ-031 Non-granted master, and any master in IDLE: waitrequest=1, readdata_valid=0.
REQ-032 Outside x_REQ: o_mem_addr, byte_en, writedata, read, write all 0.
REQ-033 x_WAIT has an 8-bit counter cleared on entry; when it reaches TIMEOUT with no valid: owner readdata_valid=1, owner readdata=0, o_timeout=1 for one cycle, next IDLE.
REQ-034 A new grant can be issued no earlier than the cycle after return to IDLE; back-to-back transactions alternate masters while both request.
Reset
REQ-035 rst low: immediately state=IDLE, last-grant=inst, counter=0, o_timeout=0, all o_mem_* 0, both waitrequest 1, both readdata_valid 0; an in-flight transaction is abandoned, and late read data is ignored after release.
Verification
REQ-036 Icache read at 0x40 alone, mem waitrequest=0, valid 3 cycles later with 0xA5..A5 -> o_inst_readdata_valid high 1 cycle with that data; o_data_readdata_valid stays 0.
REQ-037 Both read in the same cycle after reset -> dcache served first, then icache; o_mem_addr shows the dcache address, then the icache address.
REQ-038 Dcache write 0x100, byte_en 0x000F, mem waitrequest held 2 cycles -> o_data_waitrequest 1 for 2 cycles then 0; state returns to IDLE; icache stalled throughout.
REQ-039 Icache read, memory never returns valid, TIMEOUT=4 -> after 4 WAIT cycles o_inst_readdata_valid=1 with data 0 and o_timeout pulses once.
REQ-040 rst low during D_WAIT, valid arrives after release -> no readdata_valid on either master; next icache request is granted normally.
REQ-041 Icache asserts read and write together -> o_mem_write=1, o_mem_read=0, completes as a write.
